// File: rtl/weight_store_server_pkg.sv
// weight_store_server_pkg: shared geometry constants and loader/server FSM encoding
package weight_store_server_pkg;
  localparam int NUM_LAYERS = 5;
  localparam int NUM_KERNELS = 64;
  localparam int DEPTH = 3;
  localparam int KSIZE = 3;
  localparam int WEIGHT_WORDS = NUM_LAYERS * NUM_KERNELS * DEPTH * KSIZE * KSIZE;
  localparam int BIAS_WORDS = NUM_LAYERS * NUM_KERNELS;
  localparam int BIAS_BASE = WEIGHT_WORDS;
  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_B, LOAD_CK, READY, ERROR} state_t;
endpackage

// File: rtl/weight_ram.sv
// weight_ram: single-port synchronous RAM, write-enable plus read-enable, one-cycle registered read
module weight_ram #(
  parameter int WORDS = 8960,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);
  logic [31:0] mem [WORDS];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/weight_store_server.sv
// weight_store_server: loads a checksummed weight/bias byte image into RAM, then serves indexed reads.
module weight_store_server #(
  parameter int NUM_LAYERS = weight_store_server_pkg::NUM_LAYERS,
  parameter int NUM_KERNELS = weight_store_server_pkg::NUM_KERNELS,
  parameter int DEPTH = weight_store_server_pkg::DEPTH,
  parameter int KSIZE = weight_store_server_pkg::KSIZE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_start,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic               byte_ready,
  output logic               load_done,
  output logic               load_error,
  input  logic               rd_req,
  output logic               rd_ready,
  input  logic               rd_is_bias,
  input  logic [2:0]         rd_layer,
  input  logic [5:0]         rd_kernel,
  input  logic [1:0]         rd_depth,
  input  logic [1:0]         rd_ki,
  input  logic [1:0]         rd_kj,
  output logic               rd_valid,
  output logic signed [31:0] rd_data,
  output logic               rd_range_err
);
  import weight_store_server_pkg::*;
  localparam int KK = KSIZE * KSIZE;
  localparam int W_WORDS = NUM_LAYERS * NUM_KERNELS * DEPTH * KK;
  localparam int T_WORDS = W_WORDS + NUM_LAYERS * NUM_KERNELS;
  localparam int ADDR_W = $clog2(T_WORDS);
  localparam logic [ADDR_W-1:0] W_LAST = ADDR_W'(W_WORDS - 1);
  localparam logic [ADDR_W-1:0] T_LAST = ADDR_W'(T_WORDS - 1);

  state_t state_q, state_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d, ram_addr;
  logic [1:0] bcnt_q, bcnt_d;
  logic [23:0] part_q, part_d;
  logic [7:0] ck_q, ck_d;
  logic rvalid_q, rvalid_d, rerr_q, rerr_d;
  logic [31:0] hold_q, hold_d, ram_rdata;
  logic loading, take_data, word_done, rd_acc, oor;

  always_comb begin
    loading = state_q inside {LOAD_W, LOAD_B, LOAD_CK};
    take_data = byte_valid && (state_q == LOAD_W || state_q == LOAD_B);
    word_done = take_data && bcnt_q == 2'd3;
    rd_acc = rd_req && state_q == READY;
    oor = 32'(rd_layer) >= NUM_LAYERS || 32'(rd_kernel) >= NUM_KERNELS ||
          (!rd_is_bias && (32'(rd_depth) >= DEPTH || 32'(rd_ki) >= KSIZE || 32'(rd_kj) >= KSIZE));
    state_d = state_q;
    waddr_d = waddr_q;
    bcnt_d = take_data ? bcnt_q + 2'd1 : bcnt_q;
    part_d = take_data ? {byte_data, part_q[23:8]} : part_q;
    ck_d = take_data ? ck_q + byte_data : ck_q;
    if (word_done) begin
      waddr_d = waddr_q + ADDR_W'(1);
      if (waddr_q == W_LAST) state_d = LOAD_B;
      if (waddr_q == T_LAST) state_d = LOAD_CK;
    end
    if (byte_valid && state_q == LOAD_CK) state_d = (byte_data == ck_q) ? READY : ERROR;
    // a restart wins over any byte accepted in the same cycle
    if (load_start) begin
      state_d = LOAD_W;
      waddr_d = '0;
      bcnt_d = '0;
      ck_d = '0;
    end
    ram_addr = rd_is_bias
      ? ADDR_W'(W_WORDS + 32'(rd_layer) * NUM_KERNELS + 32'(rd_kernel))
      : ADDR_W'(((32'(rd_layer) * NUM_KERNELS + 32'(rd_kernel)) * DEPTH + 32'(rd_depth)) * KK
                + 32'(rd_ki) * KSIZE + 32'(rd_kj));
    if (loading) ram_addr = waddr_q;
    rvalid_d = rd_acc;
    rerr_d = rd_acc && oor;
    rd_data = rvalid_q ? (rerr_q ? '0 : ram_rdata) : hold_q;
    hold_d = rd_data;
    rd_valid = rvalid_q;
    rd_range_err = rerr_q;
    byte_ready = loading;
    load_done = state_q == READY;
    load_error = state_q == ERROR;
    rd_ready = state_q == READY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      waddr_q <= '0;
      bcnt_q <= '0;
      part_q <= '0;
      ck_q <= '0;
      rvalid_q <= 1'b0;
      rerr_q <= 1'b0;
      hold_q <= '0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      bcnt_q <= bcnt_d;
      part_q <= part_d;
      ck_q <= ck_d;
      rvalid_q <= rvalid_d;
      rerr_q <= rerr_d;
      hold_q <= hold_d;
    end
  end

  weight_ram #(.WORDS(T_WORDS), .ADDR_W(ADDR_W)) u_ram (
    .clk  (clk),
    .we   (word_done),
    .re   (rd_acc && !oor),
    .addr (ram_addr),
    .wdata({byte_data, part_q}),
    .rdata(ram_rdata)
  );
endmodule

// File: tb/tb_weight_store_server.sv
// tb_weight_store_server: three DUTs share one byte stream (A good load, B corrupted trailer, C reset mid-bias).
module tb_weight_store_server;
  logic clk = 1'b0, rst_n_a = 1'b0, rst_n_c = 1'b0;
  always #5 clk = ~clk;
  logic load_start = 1'b0, byte_valid = 1'b0, rd_req = 1'b0, rd_is_bias = 1'b0;
  logic [7:0] byte_data = '0, byte_data_b = '0, ck = '0;
  logic [2:0] rd_layer = '0;
  logic [5:0] rd_kernel = '0;
  logic [1:0] rd_depth = '0, rd_ki = '0, rd_kj = '0;
  logic [2:0] br, ld, le, rr, rv, re;
  logic signed [31:0] rdat [3];
  int errors = 0, checks = 0;

  typedef struct {
    logic b; logic [2:0] l; logic [5:0] k; logic [1:0] d; logic [1:0] i; logic [1:0] j;
    int addr; logic err;
  } vec_t;
  vec_t tbl [13];

  weight_store_server u_a (.clk(clk), .rst_n(rst_n_a), .load_start(load_start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(br[0]), .load_done(ld[0]), .load_error(le[0]), .rd_req(rd_req),
    .rd_ready(rr[0]), .rd_is_bias(rd_is_bias), .rd_layer(rd_layer), .rd_kernel(rd_kernel), .rd_depth(rd_depth),
    .rd_ki(rd_ki), .rd_kj(rd_kj), .rd_valid(rv[0]), .rd_data(rdat[0]), .rd_range_err(re[0]));
  weight_store_server u_b (.clk(clk), .rst_n(rst_n_a), .load_start(load_start), .byte_valid(byte_valid),
    .byte_data(byte_data_b), .byte_ready(br[1]), .load_done(ld[1]), .load_error(le[1]), .rd_req(rd_req),
    .rd_ready(rr[1]), .rd_is_bias(rd_is_bias), .rd_layer(rd_layer), .rd_kernel(rd_kernel), .rd_depth(rd_depth),
    .rd_ki(rd_ki), .rd_kj(rd_kj), .rd_valid(rv[1]), .rd_data(rdat[1]), .rd_range_err(re[1]));
  weight_store_server u_c (.clk(clk), .rst_n(rst_n_c), .load_start(load_start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(br[2]), .load_done(ld[2]), .load_error(le[2]), .rd_req(rd_req),
    .rd_ready(rr[2]), .rd_is_bias(rd_is_bias), .rd_layer(rd_layer), .rd_kernel(rd_kernel), .rd_depth(rd_depth),
    .rd_ki(rd_ki), .rd_kj(rd_kj), .rd_valid(rv[2]), .rd_data(rdat[2]), .rd_range_err(re[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] img(input int n);
    return 32'(n) * 32'h01010101;
  endfunction

  task automatic send_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) begin
      byte_data = w[8*b +: 8];
      byte_data_b = byte_data;
      byte_valid = 1'b1;
      ck = ck + byte_data;
      tick();
    end
    byte_valid = 1'b0;
  endtask

  task automatic set_vec(input int t);
    rd_is_bias = tbl[t].b; rd_layer = tbl[t].l; rd_kernel = tbl[t].k;
    rd_depth = tbl[t].d; rd_ki = tbl[t].i; rd_kj = tbl[t].j;
  endtask

  task automatic set_word(input int n);
    rd_is_bias = n >= 8640; rd_depth = '0; rd_ki = '0; rd_kj = '0;
    if (n < 8640) begin
      rd_layer = 3'(n / 1728); rd_kernel = 6'((n % 1728) / 27);
      rd_depth = 2'((n % 27) / 9); rd_ki = 2'((n % 9) / 3); rd_kj = 2'(n % 3);
    end else begin
      rd_layer = 3'((n - 8640) / 64); rd_kernel = 6'((n - 8640) % 64);
    end
  endtask

  task automatic chk_reset(input int x, input string tag);
    chk({tag, "_byte_ready"}, 32'(br[x]), 0);
    chk({tag, "_load_done"}, 32'(ld[x]), 0);
    chk({tag, "_load_error"}, 32'(le[x]), 0);
    chk({tag, "_rd_ready"}, 32'(rr[x]), 0);
    chk({tag, "_rd_valid"}, 32'(rv[x]), 0);
    chk({tag, "_rd_range_err"}, 32'(re[x]), 0);
    chk({tag, "_rd_data"}, rdat[x], 0);
  endtask

  initial begin
    int bad;
    logic [31:0] exp;
    tbl[0]  = '{1'b0, 3'd1, 6'd5,  2'd2, 2'd1, 2'd0, 1884, 1'b0};
    tbl[1]  = '{1'b0, 3'd0, 6'd0,  2'd0, 2'd0, 2'd0, 0,    1'b0};
    tbl[2]  = '{1'b0, 3'd4, 6'd63, 2'd2, 2'd2, 2'd2, 8639, 1'b0};
    tbl[3]  = '{1'b1, 3'd0, 6'd0,  2'd0, 2'd0, 2'd0, 8640, 1'b0};
    tbl[4]  = '{1'b1, 3'd4, 6'd63, 2'd0, 2'd0, 2'd0, 8959, 1'b0};
    tbl[5]  = '{1'b1, 3'd2, 6'd10, 2'd0, 2'd0, 2'd0, 8778, 1'b0};
    tbl[6]  = '{1'b0, 3'd5, 6'd0,  2'd0, 2'd0, 2'd0, 0,    1'b1};
    tbl[7]  = '{1'b0, 3'd0, 6'd0,  2'd3, 2'd0, 2'd0, 0,    1'b1};
    tbl[8]  = '{1'b0, 3'd0, 6'd0,  2'd0, 2'd3, 2'd0, 0,    1'b1};
    tbl[9]  = '{1'b0, 3'd0, 6'd0,  2'd0, 2'd0, 2'd3, 0,    1'b1};
    tbl[10] = '{1'b1, 3'd7, 6'd0,  2'd0, 2'd0, 2'd0, 0,    1'b1};
    tbl[11] = '{1'b1, 3'd0, 6'd1,  2'd3, 2'd3, 2'd3, 8641, 1'b0};
    tbl[12] = '{1'b0, 3'd3, 6'd17, 2'd1, 2'd0, 2'd2, 5654, 1'b0};

    tick(); tick();
    chk_reset(0, "reset");
    rst_n_a = 1'b1; rst_n_c = 1'b1;
    tick();
    chk("idle_byte_ready", 32'(br[0]), 0);

    load_start = 1'b1; tick(); load_start = 1'b0;
    chk("load_w_byte_ready", 32'(br[0]), 1);
    for (int n = 0; n < 1000; n++) send_word(img(n) ^ 32'hA5A5A5A5);
    load_start = 1'b1; tick(); load_start = 1'b0;
    ck = '0;
    for (int n = 0; n < 8960; n++) begin
      if (n == 8700) begin
        chk("c_in_load_b", 32'(br[2]), 1);
        #2 rst_n_c = 1'b0;
        #1 chk_reset(2, "async_rst");
      end
      if (n == 8702) rst_n_c = 1'b1;
      send_word(img(n));
    end
    byte_data = ck; byte_data_b = ck + 8'd1; byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
    chk("a_load_done", 32'(ld[0]), 1);
    chk("a_load_error", 32'(le[0]), 0);
    chk("a_rd_ready", 32'(rr[0]), 1);
    chk("a_byte_ready_done", 32'(br[0]), 0);
    chk("b_load_error", 32'(le[1]), 1);
    chk("b_load_done", 32'(ld[1]), 0);
    chk("b_rd_ready", 32'(rr[1]), 0);
    chk("c_byte_ready_idle", 32'(br[2]), 0);
    chk("c_load_done", 32'(ld[2]), 0);

    for (int t = 0; t < 13; t++) begin
      set_vec(t); rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      exp = tbl[t].err ? 32'd0 : img(tbl[t].addr);
      chk($sformatf("vec%0d_valid", t), 32'(rv[0]), 1);
      chk($sformatf("vec%0d_range_err", t), 32'(re[0]), 32'(tbl[t].err));
      chk($sformatf("vec%0d_data", t), rdat[0], exp);
      chk($sformatf("vec%0d_b_no_valid", t), 32'(rv[1]), 0);
      tick();
      chk($sformatf("vec%0d_valid_drop", t), 32'(rv[0]), 0);
      chk($sformatf("vec%0d_range_err_drop", t), 32'(re[0]), 0);
      chk($sformatf("vec%0d_data_hold", t), rdat[0], exp);
    end

    for (int i = 0; i < 4; i++) begin
      int t;
      t = (i == 0) ? 0 : (i == 1) ? 4 : (i == 2) ? 12 : 5;
      set_vec(t); rd_req = 1'b1;
      byte_valid = 1'($urandom_range(0, 1));
      byte_data = 8'($urandom);
      tick();
      chk($sformatf("b2b%0d_valid", i), 32'(rv[0]), 1);
      chk($sformatf("b2b%0d_data", i), rdat[0], img(tbl[t].addr));
    end
    rd_req = 1'b0; byte_valid = 1'b0;
    tick();
    chk("b2b_end_valid", 32'(rv[0]), 0);
    chk("b2b_end_hold", rdat[0], img(8778));

    bad = 0;
    for (int n = 0; n < 8960; n++) begin
      set_word(n); rd_req = 1'b1;
      tick();
      if (rv[0] !== 1'b1 || rdat[0] !== img(n)) bad++;
    end
    rd_req = 1'b0;
    chk("sweep_bad_words", 32'(bad), 0);

    set_vec(0); rd_req = 1'b1; load_start = 1'b1;
    tick();
    rd_req = 1'b0; load_start = 1'b0;
    chk("restart_read_valid", 32'(rv[0]), 1);
    chk("restart_read_data", rdat[0], img(1884));
    chk("restart_load_done_clr", 32'(ld[0]), 0);
    chk("restart_byte_ready", 32'(br[0]), 1);
    chk("restart_b_error_clr", 32'(le[1]), 0);
    chk("restart_c_byte_ready", 32'(br[2]), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/weight_store_server.md
WEIGHT_STORE_SERVER -- requirements
Module: weight_store_server

Interface
REQ-001 Parameter NUM_LAYERS, default 5, number of convolution layers.
REQ-002 Parameter NUM_KERNELS, default 64, kernels per layer.
REQ-003 Parameter DEPTH, default 3, input channels per kernel; KSIZE, default 3, kernel height/width.
REQ-004 clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-005 load_start  in  1  one-cycle pulse; begin (re)loading the model image.
REQ-006 byte_valid  in  1 / byte_data  in  8 / byte_ready  out  1  model byte stream, transfer when valid&&ready.
REQ-007 load_done  out  1  model loaded and checksum good; load_error  out  1  checksum mismatch.
REQ-008 rd_req  in  1 / rd_ready  out  1  read request handshake, accept when req&&ready.
REQ-009 rd_is_bias  in  1  select bias (1) or weight (0).
REQ-010 rd_layer  in  3 / rd_kernel  in  6 / rd_depth, rd_ki, rd_kj  in  2 each  read indices.
REQ-011 rd_valid  out  1 / rd_data  out  32 signed / rd_range_err  out  1  read response.

Function
REQ-012 FSM states SHALL be IDLE, LOAD_W, LOAD_B, LOAD_CK, READY, ERROR.
REQ-013 IDLE/READY/ERROR --load_start--> LOAD_W with word address 0, byte counter 0, running checksum 0.
REQ-014 load_start during any LOAD_* state SHALL restart at LOAD_W, discarding partial word and checksum.
REQ-015 byte_ready SHALL be 1 exactly in LOAD_W, LOAD_B, LOAD_CK.
REQ-016 Words SHALL be assembled little-endian from 4 accepted bytes; word written to RAM on the 4th byte.
REQ-017 Weight order: [layer][kernel][depth][ki][kj], kj fastest; 5*64*27 = 8640 words.
REQ-018 Weight address = ((layer*NUM_KERNELS+kernel)*DEPTH+depth)*KSIZE*KSIZE + ki*KSIZE + kj.
REQ-019 After word 8639, LOAD_W -> LOAD_B; biases 320 words, order [layer][kernel], address 8640 + layer*64 + kernel.
REQ-020 After bias word 319, LOAD_B -> LOAD_CK; one trailer byte accepted.
REQ-021 Checksum = sum mod 256 of all 35840 weight/bias bytes; trailer equal -> READY, load_done=1; else -> ERROR, load_error=1.
REQ-022 load_done and load_error SHALL clear in the cycle after load_start is sampled.
REQ-023 rd_ready SHALL be 1 only in READY; rd_req outside READY ignored, no rd_valid.
REQ-024 Accepted read: rd_valid=1 for exactly one cycle, 1 cycle after acceptance, rd_data = stored word; back-to-back reads every cycle SHALL be supported.
REQ-025 Out of range (layer>=NUM_LAYERS, depth>=DEPTH, ki/kj>=KSIZE; depth/ki/kj ignored when rd_is_bias): rd_valid=1, rd_data=0, rd_range_err=1 same cycle, no RAM access.
REQ-026 load_start in same cycle as accepted rd_req: read SHALL complete (rd_valid next cycle), load begins.
REQ-027 rd_valid, rd_range_err deasserted when no response; rd_data holds last value.

Reset
REQ-028 rst_n low: state IDLE, counters/checksum 0, byte_ready=0, load_done=0, load_error=0, rd_ready=0, rd_valid=0, rd_range_err=0, rd_data=0.
REQ-029 Reset mid-load SHALL abandon the load; RAM contents undefined, load_done stays 0 until a full good load.

Structure
REQ-030 Shared package SHALL hold NUM_LAYERS, NUM_KERNELS, DEPTH, KSIZE, WEIGHT_WORDS=8640, BIAS_WORDS=320, BIAS_BASE=8640, state enum.
REQ-031 One sub-module weight_ram: single-port synchronous 8960x32 RAM, 1-cycle read, write-enable; loader and reader share the port, arbitrated by FSM state.

Verification
REQ-032 Full load, word n = n*0x01010101 (low bytes), correct checksum -> load_done=1 after trailer; read weight (1,5,2,1,0) -> rd_data = word 1*1728+5*27+2*9+3 = 1884 value, 1 cycle later.
REQ-033 Same image, trailer checksum+1 -> load_error=1, load_done=0, rd_ready=0; rd_req produces no rd_valid.
REQ-034 Read bias layer 4 kernel 63 -> word 8959; read layer 5 -> rd_data=0, rd_range_err=1.
REQ-035 load_start after 1000 words, then full good load -> load_done=1, all 8960 words match second image.
REQ-036 Back-to-back rd_req for 4 cycles with byte_valid toggling randomly -> 4 consecutive rd_valid pulses, correct data, no loss.
REQ-037 rst_n asserted mid-LOAD_B -> all outputs at reset values asynchronously; byte_ready=0 until next load_start.
